// File: rtl/cpu_unified_mem.sv
// -----------------------------------------------------------------------------
// cpu_unified_mem
//   Synchronous unified instruction/data memory shared by the CPU and a
//   program loader. The CPU reads every cycle through a read pipeline of
//   depth RD_LAT and writes on its store strobe. The loader writes through a
//   valid/ready handshake while the CPU is held off (run = 0).
//
// Optional feature (compile-time macro):
//   MEM_WR_FORWARD_EN - when defined, a write to an in-range address is
//   forwarded into every in-flight read sample of the same address, including
//   a read taken on the same edge. The data returned is then always the newest
//   value at the moment the sample emerges. When the macro is undefined, reads
//   are read-first and no forwarding comparators exist.
//
// Parameters:
//   DATA_W  word width
//   ADDR_W  address width
//   DEPTH   implemented words; addresses >= DEPTH are out of range
//           (DEPTH <= 2**ADDR_W)
//   RD_LAT  CPU read latency in cycles, 1..4
//   CNT_W   width of the saturating write counter
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   run       1 = CPU owns the memory, 0 = loader owns it
//   address   CPU word address, sampled every cycle
//   data_out  CPU store data
//   mem_we    CPU write strobe
//   data_in   read data returned to the CPU (0 when not valid)
//   rd_valid  data_in belongs to the address presented RD_LAT cycles earlier
//   ld_valid  loader word valid
//   ld_ready  loader may transfer (registered copy of !run)
//   ld_addr   loader word address
//   ld_data   loader word
//   addr_err  one-cycle pulse for an out-of-range access
//   wr_count  number of accepted writes since reset (saturating)
// -----------------------------------------------------------------------------
module cpu_unified_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 255,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_out,
    input  logic              mem_we,
    output logic [DATA_W-1:0] data_in,
    output logic              rd_valid,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              addr_err,
    output logic [CNT_W-1:0]  wr_count
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    // NOTE: the storage array has no reset; contents survive rst_n and are
    // initialised by the loader, which keeps it mappable onto block RAM.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read pipeline. Stage RD_LAT-1 drives the outputs directly.
    logic [RD_LAT-1:0]             r_pv;   // sample taken while run = 1
    logic [RD_LAT-1:0]             r_pe;   // sample address was out of range
    logic [RD_LAT-1:0][DATA_W-1:0] r_pd;   // sample data (0 unless valid and in range)
`ifdef MEM_WR_FORWARD_EN
    logic [RD_LAT-1:0][ADDR_W-1:0] r_pa;   // sample address, for forwarding
`endif

    logic             r_ld_ready;
    logic             r_wr_err;
    logic [CNT_W-1:0] r_wr_count;

    logic              w_cpu_oob;
    logic              w_ld_oob;
    logic              w_ld_fire;
    logic              w_cpu_wr;
    logic              w_wr_en;
    logic              w_wr_drop;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_s0_ok;
    logic [RD_LAT-1:0][DATA_W-1:0] w_next_data;

    // An unknown CPU address is treated as out of range so it reads back 0.
    assign w_cpu_oob = ({1'b0, address} >= DEPTH_W) || $isunknown(address);
    assign w_ld_oob  = ({1'b0, ld_addr} >= DEPTH_W);

    // Ownership is exclusive through run; the loader wins the single cycle in
    // which ld_ready still lags a rising run, so a beat is never half-taken.
    assign w_ld_fire = ld_valid && r_ld_ready;
    assign w_cpu_wr  = run && mem_we && !w_ld_fire;

    // Writes are blocked while reset is asserted so an in-flight beat or store
    // coinciding with a reset edge never lands in the array.
    assign w_wr_en   = rst_n && ((w_ld_fire && !w_ld_oob) || (w_cpu_wr && !w_cpu_oob));
    assign w_wr_drop = (w_ld_fire && w_ld_oob) || (w_cpu_wr && w_cpu_oob);
    assign w_wr_addr = w_ld_fire ? ld_addr : address;
    assign w_wr_data = w_ld_fire ? ld_data : data_out;

    assign w_rd_word = r_mem[address];
    assign w_s0_ok   = run && !w_cpu_oob;

    // Next value of each pipeline data stage, including optional forwarding.
    // NOTE: every element is assigned before any conditional override, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        w_next_data[0] = w_s0_ok ? w_rd_word : '0;
`ifdef MEM_WR_FORWARD_EN
        if (w_s0_ok && w_wr_en && (w_wr_addr == address)) begin
            w_next_data[0] = w_wr_data;
        end
`endif
        for (int k = 1; k < RD_LAT; k++) begin
            w_next_data[k] = r_pd[k-1];
`ifdef MEM_WR_FORWARD_EN
            // Only valid in-range samples carry real data worth refreshing.
            if (r_pv[k-1] && !r_pe[k-1] && w_wr_en && (w_wr_addr == r_pa[k-1])) begin
                w_next_data[k] = w_wr_data;
            end
`endif
        end
    end

    // Array write port. Read-first: w_rd_word above sees the old contents on
    // the same edge.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv       <= '0;
            r_pe       <= '0;
            r_pd       <= '0;
`ifdef MEM_WR_FORWARD_EN
            r_pa       <= '0;
`endif
            r_ld_ready <= 1'b0;
            r_wr_err   <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_pv[0] <= run;
            r_pe[0] <= run && w_cpu_oob;
`ifdef MEM_WR_FORWARD_EN
            r_pa[0] <= address;
`endif
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pe[k] <= r_pe[k-1];
`ifdef MEM_WR_FORWARD_EN
                r_pa[k] <= r_pa[k-1];
`endif
            end
            r_pd       <= w_next_data;
            r_ld_ready <= !run;
            r_wr_err   <= w_wr_drop;
            if (w_wr_en && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    assign data_in  = r_pd[RD_LAT-1];
    assign rd_valid = r_pv[RD_LAT-1];
    assign addr_err = r_pe[RD_LAT-1] | r_wr_err;
    assign ld_ready = r_ld_ready;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_cpu_unified_mem.sv
// -----------------------------------------------------------------------------
// tb_cpu_unified_mem
//   Self-checking bench for cpu_unified_mem with a three-cycle read latency.
//   A transaction-level model (word array plus a queue of in-flight read
//   samples) predicts every output after every clock edge; directed sequences
//   cover preload, stores, range errors, read-during-write and reset during a
//   load, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_cpu_unified_mem;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 255;
    localparam int RD_LAT = 3;
    localparam int CNT_W  = 16;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              run      = 1'b0;
    logic [ADDR_W-1:0] address  = '0;
    logic [DATA_W-1:0] data_out = '0;
    logic              mem_we   = 1'b0;
    logic              ld_valid = 1'b0;
    logic [ADDR_W-1:0] ld_addr  = '0;
    logic [DATA_W-1:0] ld_data  = '0;
    logic [DATA_W-1:0] data_in;
    logic              rd_valid;
    logic              ld_ready;
    logic              addr_err;
    logic [CNT_W-1:0]  wr_count;

    cpu_unified_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .address (address),
        .data_out(data_out),
        .mem_we  (mem_we),
        .data_in (data_in),
        .rd_valid(rd_valid),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .addr_err(addr_err),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        bit          e;
        int          a;
        logic [15:0] d;
    } samp_t;

    logic [15:0] m_mem [DEPTH];
    samp_t       m_q[$];        // last RD_LAT samples, m_q[0] is on the outputs
    bit          m_ld_ready;
    bit          m_wr_err;
    int          m_count;

    function automatic void model_reset();
        samp_t z;
        z = '{v: 1'b0, e: 1'b0, a: 0, d: 16'h0};
        m_q.delete();
        for (int i = 0; i < RD_LAT; i++) m_q.push_back(z);
        m_ld_ready = 1'b0;
        m_wr_err   = 1'b0;
        m_count    = 0;
    endfunction

    // Apply one clock edge using the inputs currently driven.
    function automatic void model_edge();
        samp_t       s;
        bit          wen;
        int          wa;
        logic [15:0] wd;
        wen      = 1'b0;
        wa       = 0;
        wd       = 16'h0;
        m_wr_err = 1'b0;
        if (ld_valid && m_ld_ready) begin
            if (int'(ld_addr) < DEPTH) begin
                wen = 1'b1; wa = int'(ld_addr); wd = ld_data;
            end else begin
                m_wr_err = 1'b1;
            end
        end else if (run && mem_we) begin
            if (int'(address) < DEPTH) begin
                wen = 1'b1; wa = int'(address); wd = data_out;
            end else begin
                m_wr_err = 1'b1;
            end
        end
        // Read sees the contents from before this edge's write.
        s.v = run;
        s.e = run && (int'(address) >= DEPTH);
        s.a = int'(address);
        s.d = (s.v && !s.e) ? m_mem[s.a] : 16'h0;
        if (wen) begin
            m_mem[wa] = wd;
            if (m_count < 65535) m_count++;
        end
        m_q.push_back(s);
        void'(m_q.pop_front());
`ifdef MEM_WR_FORWARD_EN
        if (wen) begin
            foreach (m_q[i]) begin
                if (m_q[i].v && !m_q[i].e && m_q[i].a == wa) m_q[i].d = wd;
            end
        end
`endif
        m_ld_ready = !run;
    endfunction

    task automatic compare_all();
        check("data_in",  32'(data_in),  32'(m_q[0].d));
        check("rd_valid", 32'(rd_valid), 32'(m_q[0].v));
        check("addr_err", 32'(addr_err), 32'(m_q[0].e | m_wr_err));
        check("ld_ready", 32'(ld_ready), 32'(m_ld_ready));
        check("wr_count", 32'(wr_count), 32'(m_count));
    endtask

    // One clock: inputs are already driven; sample 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic cpu(input bit r, input int a, input bit we, input logic [15:0] d);
        run = r; address = ADDR_W'(a); mem_we = we; data_out = d; ld_valid = 1'b0;
        cycle();
    endtask

    task automatic load(input int a, input logic [15:0] d);
        run = 1'b0; mem_we = 1'b0; ld_valid = 1'b1; ld_addr = ADDR_W'(a); ld_data = d;
        cycle();
        ld_valid = 1'b0;
    endtask

    task automatic read_word(input int a, output logic [15:0] d);
        cpu(1'b1, a, 1'b0, 16'h0);
        repeat (RD_LAT - 1) cpu(1'b1, 0, 1'b0, 16'h0);
        d = data_in;
    endtask

    // Assert reset between edges, hold it across one edge, release mid-cycle.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_data_in",  32'(data_in),  32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_ld_ready", 32'(ld_ready), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        check("rst_wr_count", 32'(wr_count), 32'h0);
        cycle();
        #3 rst_n = 1'b1;
    endtask

    logic [15:0] rd;
    logic [15:0] cnt_before;

    initial begin
        model_reset();
        #12;
        check("init_data_in",  32'(data_in),  32'h0);
        check("init_rd_valid", 32'(rd_valid), 32'h0);
        check("init_ld_ready", 32'(ld_ready), 32'h0);
        check("init_wr_count", 32'(wr_count), 32'h0);
        rst_n = 1'b1;

        // Clear the whole array through the loader, then reset the counters.
        cpu(1'b0, 0, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) load(i, 16'h0000);
        async_reset();

        // Preload.
        cpu(1'b0, 0, 1'b0, 16'h0);
        load(50, 16'h00AA);
        load(51, 16'h0055);
        check("preload_count", 32'(wr_count), 32'd2);
        load(52, 16'h0003);

        // Back-to-back reads with RD_LAT = 3.
        cpu(1'b1, 50, 1'b0, 16'h0);
        check("ld_ready_drop", 32'(ld_ready), 32'h0);
        cpu(1'b1, 51, 1'b0, 16'h0);
        cpu(1'b1, 52, 1'b0, 16'h0);
        check("rd50", 32'(data_in), 32'h00AA);
        check("rd50_v", 32'(rd_valid), 32'h1);
        cpu(1'b1, 0, 1'b0, 16'h0);
        check("rd51", 32'(data_in), 32'h0055);
        cpu(1'b1, 0, 1'b0, 16'h0);
        check("rd52", 32'(data_in), 32'h0003);
        check("rd52_v", 32'(rd_valid), 32'h1);

        // CPU store.
        cnt_before = wr_count;
        cpu(1'b1, 102, 1'b1, 16'h00FF);
        check("store_count", 32'(wr_count), 32'(cnt_before + 16'd1));
        read_word(102, rd);
        check("store_rd", 32'(rd), 32'h00FF);

        // Out-of-range read and write.
        read_word(255, rd);
        check("oob_rd_data", 32'(rd), 32'h0);
        check("oob_rd_err", 32'(addr_err), 32'h1);
        cpu(1'b1, 0, 1'b0, 16'h0);
        check("oob_rd_err_end", 32'(addr_err), 32'h0);
        cnt_before = wr_count;
        cpu(1'b1, 255, 1'b1, 16'hDEAD);
        check("oob_wr_err", 32'(addr_err), 32'h1);
        check("oob_wr_count", 32'(wr_count), 32'(cnt_before));
        repeat (RD_LAT) cpu(1'b1, 0, 1'b0, 16'h0);

        // Same-address read/write on one edge.
        cpu(1'b1, 50, 1'b1, 16'h1234);
        repeat (RD_LAT - 1) cpu(1'b1, 0, 1'b0, 16'h0);
`ifdef MEM_WR_FORWARD_EN
        check("rdw_same_edge", 32'(data_in), 32'h1234);
`else
        check("rdw_same_edge", 32'(data_in), 32'h00AA);
`endif
        read_word(50, rd);
        check("rdw_after", 32'(rd), 32'h1234);

        // Write one edge after the read of the same address is in flight.
        cpu(1'b1, 51, 1'b0, 16'h0);
        cpu(1'b1, 51, 1'b1, 16'h7777);
        cpu(1'b1, 0, 1'b0, 16'h0);
`ifdef MEM_WR_FORWARD_EN
        check("rdw_inflight", 32'(data_in), 32'h7777);
`else
        check("rdw_inflight", 32'(data_in), 32'h0055);
`endif
        repeat (RD_LAT) cpu(1'b1, 0, 1'b0, 16'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            address  = ADDR_W'($urandom_range(0, 255));
            data_out = DATA_W'($urandom);
            mem_we   = ($urandom_range(0, 3) == 0);
            ld_valid = !run && ($urandom_range(0, 1) == 1);
            ld_addr  = ADDR_W'($urandom_range(0, 255));
            ld_data  = DATA_W'($urandom);
            cycle();
        end

        // Reset in the middle of a load.
        cpu(1'b0, 0, 1'b0, 16'h0);
        load(201, 16'h1111);
        load(200, 16'hBEEF);
        ld_valid = 1'b1; ld_addr = ADDR_W'(201); ld_data = 16'hCAFE;
        async_reset();
        ld_valid = 1'b0;
        check("midload_count", 32'(wr_count), 32'h0);
        read_word(200, rd);
        check("midload_kept", 32'(rd), 32'hBEEF);
        read_word(201, rd);
        check("midload_dropped", 32'(rd), 32'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
